// File: rtl/formant_dp_pkg.sv
// formant_dp_pkg: shared cost/index types, FSM states and saturating add for the formant DP sweep
package formant_dp_pkg;
  localparam int COST_W = 32;
  localparam int I_DEF = 160;
  localparam int JW = $clog2(I_DEF) + 1;
  typedef logic [COST_W-1:0] cost_t;
  localparam cost_t COST_INF = '1;
  typedef logic signed [JW-1:0] jidx_t;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SWEEP, S_DRAIN, S_EMIT} state_t;
  // INF is absorbing; a carry out of the top bit also saturates to INF
  function automatic cost_t sat_add(cost_t a, cost_t b);
    logic [COST_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (a == COST_INF || b == COST_INF || s[COST_W]) ? COST_INF : s[COST_W-1:0];
  endfunction
endpackage

// File: rtl/dp_min_acc.sv
// dp_min_acc: running minimum with backpointer; strict compare keeps the earliest j on ties
module dp_min_acc
  import formant_dp_pkg::*;
(
  input  logic  clk_in,
  input  logic  rst_in,
  input  logic  clr_i,
  input  logic  upd_i,
  input  cost_t cand_i,
  input  jidx_t j_i,
  output cost_t acc_o,
  output jidx_t b_o
);
  cost_t acc_q, acc_d;
  jidx_t b_q, b_d;
  logic  take;
  // next value: clear wins, otherwise take a strictly smaller candidate
  always_comb begin
    take  = upd_i && (cand_i < acc_q);
    acc_d = clr_i ? COST_INF : take ? cand_i : acc_q;
    b_d   = clr_i ? '1 : take ? j_i : b_q;
  end
  assign acc_o = acc_d;
  assign b_o   = b_d;
  // state register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc_q <= COST_INF;
      b_q   <= '1;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
    end
  end
endmodule

// File: rtl/formant_dp_sweep.sv
// formant_dp_sweep: per-frame formant DP min-search over j for k = 1..K_eff with external latency-READ_LAT memories
module formant_dp_sweep
  import formant_dp_pkg::*;
#(
  parameter int BIT_WIDTH = COST_W,
  parameter int I         = I_DEF,
  parameter int FORMANTS  = 5,
  parameter int READ_LAT  = 2,
  parameter bit PEN_EN    = 1'b0
)(
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           begin_iter,
  input  logic [$clog2(I)-1:0]           i,
  input  logic [$clog2(FORMANTS+1)-1:0]  n_formants,
  input  logic [BIT_WIDTH-1:0]           trans_pen,
  input  logic [BIT_WIDTH-1:0]           e_prev,
  input  logic [BIT_WIDTH-1:0]           f_prev,
  output logic                           req_valid,
  output logic [$clog2(FORMANTS+1)-1:0]  k_req,
  output logic [$clog2(I):0]             j_req,
  output logic                           busy,
  output logic                           output_valid,
  output logic [$clog2(FORMANTS+1)-1:0]  k_write,
  output logic [BIT_WIDTH-1:0]           f_data,
  output logic [$clog2(I):0]             b_data,
  output logic                           iter_done
);
  localparam int KW = $clog2(FORMANTS + 1);
  localparam int IW = $clog2(I);
  state_t            state_q;
  logic [IW-1:0]     i_q;
  logic [KW-1:0]     k_q, kmax_q, kmax_d, nf_eff;
  logic [IW:0]       i_p1;
  cost_t             pen_q, cand, acc_nx;
  jidx_t             jlast, jr, b_nx;
  logic              req_valid_q, busy_q, output_valid_q, iter_done_q;
  logic [KW-1:0]     k_req_q, k_write_q;
  jidx_t             j_req_q, b_data_q;
  cost_t             f_data_q;
  logic [READ_LAT-1:0] pv_q, pl_q;
  jidx_t             pj_q [READ_LAT];
  // K_eff = min(max(n_formants,1), i+1); last j of a sweep is i-1
  always_comb begin
    nf_eff = (n_formants == '0) ? KW'(1) : n_formants;
    i_p1   = {1'b0, i} + (IW+1)'(1);
    kmax_d = (i_p1 < (IW+1)'(nf_eff)) ? KW'(i_p1) : nf_eff;
    jlast  = jidx_t'(i_q) - jidx_t'(1);
  end
  // candidate for the response leaving the read pipeline; F(0,-1)=0 and F(0,j>=0)=INF
  always_comb begin
    jr   = pj_q[READ_LAT-1];
    cand = jr[JW-1] ? ((k_q == KW'(1)) ? e_prev : COST_INF)
         : (k_q == KW'(1)) ? COST_INF
         : sat_add(sat_add(e_prev, f_prev), PEN_EN ? pen_q : '0);
  end
  dp_min_acc u_acc (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clr_i  (state_q == S_SETUP),
    .upd_i  (pv_q[READ_LAT-1]),
    .cand_i (cand),
    .j_i    (jr),
    .acc_o  (acc_nx),
    .b_o    (b_nx)
  );
  // request tracking pipeline matching the memory read latency
  always_ff @(posedge clk_in) begin
    for (int n = READ_LAT - 1; n > 0; n--) begin
      pv_q[n] <= pv_q[n-1];
      pl_q[n] <= pl_q[n-1];
      pj_q[n] <= pj_q[n-1];
    end
    pv_q[0] <= req_valid_q;
    pl_q[0] <= (j_req_q == jlast);
    pj_q[0] <= j_req_q;
    if (rst_in) pv_q <= '0;
  end
  // control FSM with registered outputs; results load from the accumulator's next value on entry to EMIT
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= S_IDLE;
      i_q            <= '0;
      k_q            <= '0;
      kmax_q         <= '0;
      pen_q          <= '0;
      req_valid_q    <= 1'b0;
      k_req_q        <= '0;
      j_req_q        <= '0;
      busy_q         <= 1'b0;
      output_valid_q <= 1'b0;
      k_write_q      <= '0;
      f_data_q       <= '0;
      b_data_q       <= '0;
      iter_done_q    <= 1'b0;
    end else begin
      output_valid_q <= 1'b0;
      iter_done_q    <= 1'b0;
      case (state_q)
        S_IDLE: if (begin_iter) begin
          i_q     <= i;
          kmax_q  <= kmax_d;
          pen_q   <= trans_pen;
          k_q     <= KW'(1);
          busy_q  <= 1'b1;
          state_q <= S_SETUP;
        end
        S_SETUP: begin
          req_valid_q <= 1'b1;
          k_req_q     <= k_q;
          j_req_q     <= jidx_t'(k_q) - jidx_t'(2);
          state_q     <= S_SWEEP;
        end
        S_SWEEP: if (j_req_q == jlast) begin
          req_valid_q <= 1'b0;
          state_q     <= S_DRAIN;
        end else begin
          j_req_q <= j_req_q + jidx_t'(1);
        end
        S_DRAIN: if (pv_q[READ_LAT-1] && pl_q[READ_LAT-1]) begin
          output_valid_q <= 1'b1;
          k_write_q      <= k_q;
          f_data_q       <= acc_nx;
          b_data_q       <= b_nx;
          iter_done_q    <= (k_q == kmax_q);
          state_q        <= S_EMIT;
        end
        S_EMIT: if (k_q == kmax_q) begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end else begin
          k_q     <= k_q + KW'(1);
          state_q <= S_SETUP;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign req_valid    = req_valid_q;
  assign k_req        = k_req_q;
  assign j_req        = j_req_q;
  assign busy         = busy_q;
  assign output_valid = output_valid_q;
  assign k_write      = k_write_q;
  assign f_data       = f_data_q;
  assign b_data       = b_data_q;
  assign iter_done    = iter_done_q;
endmodule

// File: tb/tb_formant_dp_sweep.sv
// tb_formant_dp_sweep: scoreboard bench; DUT a = READ_LAT 2 no penalty, DUT b = READ_LAT 3 with penalty
module tb_formant_dp_sweep;
  localparam logic [63:0] INF = 64'hFFFF_FFFF;
  typedef struct {
    int          k;
    logic [31:0] f;
    logic [8:0]  b;
    bit          done;
    int          lat;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_in, begin_iter;
  logic [7:0]  i_s;
  logic [2:0]  nf_s;
  logic [31:0] pen_s;
  logic [31:0] e_a, f_a, e_b, f_b;
  logic        rv_a, busy_a, ov_a, done_a, rv_b, busy_b, ov_b, done_b;
  logic [2:0]  kr_a, kw_a, kr_b, kw_b;
  logic [8:0]  jr_a, bd_a, jr_b, bd_b;
  logic [31:0] fd_a, fd_b;
  logic [31:0] em [8];
  logic [31:0] fm [6][8];
  logic [31:0] ea_p [2], fa_p [2], eb_p [3], fb_p [3];
  exp_t        qa[$], qb[$];
  int          since [2];
  bit          bprev [2];
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  formant_dp_sweep #(.READ_LAT(2), .PEN_EN(1'b0)) dut_a (
    .clk_in(clk), .rst_in(rst_in), .begin_iter(begin_iter), .i(i_s), .n_formants(nf_s),
    .trans_pen(pen_s), .e_prev(e_a), .f_prev(f_a), .req_valid(rv_a), .k_req(kr_a), .j_req(jr_a),
    .busy(busy_a), .output_valid(ov_a), .k_write(kw_a), .f_data(fd_a), .b_data(bd_a), .iter_done(done_a));
  formant_dp_sweep #(.READ_LAT(3), .PEN_EN(1'b1)) dut_b (
    .clk_in(clk), .rst_in(rst_in), .begin_iter(begin_iter), .i(i_s), .n_formants(nf_s),
    .trans_pen(pen_s), .e_prev(e_b), .f_prev(f_b), .req_valid(rv_b), .k_req(kr_b), .j_req(jr_b),
    .busy(busy_b), .output_valid(ov_b), .k_write(kw_b), .f_data(fd_b), .b_data(bd_b), .iter_done(done_b));

  function automatic logic [31:0] mem_e(logic [8:0] j);
    int jj;
    jj = int'($signed(j));
    return (jj + 1 >= 0 && jj + 1 < 8) ? em[jj+1] : 32'd0;
  endfunction
  function automatic logic [31:0] mem_f(logic [2:0] k, logic [8:0] j);
    int jj, kk;
    jj = int'($signed(j));
    kk = int'(k);
    return (jj >= 0 && jj < 8 && kk >= 1 && kk <= 5) ? fm[kk-1][jj] : 32'd0;
  endfunction

  always @(posedge clk) begin
    ea_p[0] <= mem_e(jr_a);
    fa_p[0] <= mem_f(kr_a, jr_a);
    ea_p[1] <= ea_p[0];
    fa_p[1] <= fa_p[0];
    eb_p[0] <= mem_e(jr_b);
    fb_p[0] <= mem_f(kr_b, jr_b);
    eb_p[1] <= eb_p[0];
    fb_p[1] <= fb_p[0];
    eb_p[2] <= eb_p[1];
    fb_p[2] <= fb_p[1];
  end
  assign e_a = ea_p[1];
  assign f_a = fa_p[1];
  assign e_b = eb_p[2];
  assign f_b = fb_p[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic longint satm(longint a, longint b, longint p);
    longint s;
    if (a == INF || b == INF || p == INF) return INF;
    s = a + b + p;
    return (s >= INF) ? INF : s;
  endfunction

  task automatic expect_run(input int d, input int iv, input int nf, input longint pen, input int rl);
    int     kef, b;
    longint acc, cand;
    exp_t   e;
    kef = (nf == 0) ? 1 : nf;
    if (kef > iv + 1) kef = iv + 1;
    for (int k = 1; k <= kef; k++) begin
      acc = INF;
      b = -1;
      for (int j = k - 2; j <= iv - 1; j++) begin
        if (j < 0) cand = (k == 1) ? longint'(em[0]) : INF;
        else if (k == 1) cand = INF;
        else cand = satm(longint'(em[j+1]), longint'(fm[k-1][j]), pen);
        if (cand < acc) begin
          acc = cand;
          b = j;
        end
      end
      e.k = k;
      e.f = acc[31:0];
      e.b = 9'(b);
      e.done = (k == kef);
      e.lat = (iv - k + 2) + rl + 2;
      if (d == 0) qa.push_back(e);
      else qb.push_back(e);
    end
  endtask

  task automatic score(input int d, input logic bz, input logic ov, input logic dn,
                       input logic [2:0] kw, input logic [31:0] fd, input logic [8:0] bd);
    exp_t  e;
    string p;
    p = (d == 0) ? "a_" : "b_";
    since[d] = (bz && !bprev[d]) ? 1 : since[d] + 1;
    bprev[d] = bz;
    if (ov) begin
      if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) chk({p, "unexpected_valid"}, 64'd1, 64'd0);
      else begin
        e = (d == 0) ? qa.pop_front() : qb.pop_front();
        chk({p, "k_write"}, 64'(kw), 64'(e.k));
        chk({p, "f_data"}, 64'(fd), 64'(e.f));
        chk({p, "b_data"}, 64'(bd), 64'(e.b));
        chk({p, "iter_done"}, 64'(dn), 64'(e.done));
        chk({p, "latency"}, 64'(since[d]), 64'(e.lat));
      end
      since[d] = 0;
    end
  endtask

  always @(negedge clk) if (!rst_in) begin
    score(0, busy_a, ov_a, done_a, kw_a, fd_a, bd_a);
    score(1, busy_b, ov_b, done_b, kw_b, fd_b, bd_b);
  end

  task automatic run(input int iv, input int nf, input logic [31:0] pen, input bit repulse);
    int n;
    @(negedge clk);
    i_s = 8'(iv);
    nf_s = 3'(nf);
    pen_s = pen;
    begin_iter = 1'b1;
    expect_run(0, iv, nf, 0, 2);
    expect_run(1, iv, nf, longint'(pen), 3);
    @(negedge clk);
    begin_iter = 1'b0;
    if (repulse) begin
      repeat (2) @(negedge clk);
      i_s = 8'd0;
      nf_s = 3'd1;
      pen_s = 32'd99;
      begin_iter = 1'b1;
      @(negedge clk);
      begin_iter = 1'b0;
    end
    n = 0;
    while ((busy_a || busy_b) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("run_finished", 64'(n < 2000), 64'd1);
  endtask

  task automatic clear_mem();
    for (int x = 0; x < 8; x++) begin
      em[x] = 32'd0;
      for (int y = 0; y < 6; y++) fm[y][x] = 32'd0;
    end
  endtask

  function automatic logic [31:0] rnd_cost();
    int r;
    r = int'($urandom_range(0, 7));
    return (r == 0) ? 32'hFFFF_FFFF : (r == 1) ? 32'hFFFF_FF00 + $urandom_range(0, 255) : 32'($urandom_range(0, 60));
  endfunction

  initial begin
    rst_in = 1'b1;
    begin_iter = 1'b0;
    i_s = '0;
    nf_s = '0;
    pen_s = '0;
    since[0] = 0;
    since[1] = 0;
    bprev[0] = 1'b0;
    bprev[1] = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_req_valid", 64'(rv_a), 64'd0);
    chk("rst_output_valid", 64'(ov_b), 64'd0);
    chk("rst_iter_done", 64'(done_a), 64'd0);
    chk("rst_f_data", 64'(fd_a), 64'd0);
    chk("rst_b_data", 64'(bd_b), 64'd0);
    chk("rst_j_req", 64'(jr_a), 64'd0);
    rst_in = 1'b0;
    em[0] = 32'd7;
    run(0, 5, 32'd0, 1'b0);
    clear_mem();
    em[0] = 32'd9;
    em[1] = 32'd4;
    em[2] = 32'd6;
    fm[1][0] = 32'd3;
    fm[1][1] = 32'd1;
    run(2, 2, 32'd0, 1'b1);
    run(2, 2, 32'd5, 1'b0);
    clear_mem();
    em[0] = 32'd3;
    em[1] = 32'hFFFF_FFF0;
    fm[1][0] = 32'h20;
    run(1, 2, 32'd0, 1'b0);
    for (int x = 0; x < 8; x++) em[x] = 32'($urandom_range(1, 40));
    run(3, 0, 32'd2, 1'b0);
    for (int t = 0; t < 6; t++) begin
      for (int x = 0; x < 8; x++) begin
        em[x] = rnd_cost();
        for (int y = 0; y < 6; y++) fm[y][x] = rnd_cost();
      end
      run(int'($urandom_range(2, 6)), int'($urandom_range(1, 5)), 32'($urandom_range(0, 9)), 1'b0);
    end
    @(negedge clk);
    i_s = 8'd5;
    nf_s = 3'd3;
    pen_s = 32'd0;
    begin_iter = 1'b1;
    @(negedge clk);
    begin_iter = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_sweep_req_valid", 64'(rv_a), 64'd1);
    rst_in = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(busy_a), 64'd0);
    chk("abort_req_valid", 64'(rv_b), 64'd0);
    chk("abort_output_valid", 64'(ov_a), 64'd0);
    chk("abort_iter_done", 64'(done_b), 64'd0);
    chk("abort_f_data", 64'(fd_a), 64'd0);
    rst_in = 1'b0;
    repeat (20) @(negedge clk);
    clear_mem();
    em[0] = 32'd9;
    em[1] = 32'd4;
    em[2] = 32'd6;
    fm[1][0] = 32'd3;
    fm[1][1] = 32'd1;
    run(2, 5, 32'd5, 1'b0);
    repeat (5) @(negedge clk);
    chk("a_queue_empty", 64'(qa.size()), 64'd0);
    chk("b_queue_empty", 64'(qb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
